// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-cycle stage enables, bubbles and PC redirect,
// including a held redirect while a fetch is outstanding, plus a saturating stall counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_wait,
    input  logic        mem_wait,
    input  logic        d_branch_taken,
    input  logic        d_jump_taken,
    input  logic [31:0] d_target,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic        d_use_rs,
    input  logic        d_use_rt,
    input  logic        e_mem_read,
    input  logic [4:0]  e_rd,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_en,
    output logic        em_en,
    output logic        mw_en,
    output logic        fd_flush,
    output logic        de_flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        discard_fetch,
    output logic [31:0] stall_cnt
);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic redirect;
    logic load_use;

    assign redirect = d_branch_taken | d_jump_taken;
    assign load_use = e_mem_read && (e_rd != 5'd0) &&
                      ((d_use_rs && (d_rs == e_rd)) || (d_use_rt && (d_rt == e_rd)));

    always_comb begin
        pc_en         = 1'b1;
        fd_en         = 1'b1;
        de_en         = 1'b1;
        em_en         = 1'b1;
        mw_en         = 1'b1;
        fd_flush      = 1'b0;
        de_flush      = 1'b0;
        pc_redirect   = 1'b0;
        discard_fetch = 1'b0;
        pc_target     = d_target;
        state_d       = state_q;
        pend_target_d = pend_target_q;

        if (reset) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            de_en     = 1'b0;
            em_en     = 1'b0;
            mw_en     = 1'b0;
            pc_target = 32'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        pc_en = 1'b0;
                        fd_en = 1'b0;
                        de_en = 1'b0;
                        em_en = 1'b0;
                        mw_en = 1'b0;
                    end else if (load_use) begin
                        // Decode operands are stale, so any redirect it computed is ignored.
                        pc_en    = 1'b0;
                        fd_en    = 1'b0;
                        de_flush = 1'b1;
                    end else if (redirect && !if_wait) begin
                        pc_redirect = 1'b1;
                        fd_flush    = 1'b1;
                    end else if (redirect) begin
                        pc_en         = 1'b0;
                        fd_flush      = 1'b1;
                        pend_target_d = d_target;
                        state_d       = PEND;
                    end else if (if_wait) begin
                        pc_en    = 1'b0;
                        fd_flush = 1'b1;
                    end
                end
                PEND: begin
                    if (mem_wait) begin
                        pc_en = 1'b0;
                        fd_en = 1'b0;
                        de_en = 1'b0;
                        em_en = 1'b0;
                        mw_en = 1'b0;
                    end else if (if_wait) begin
                        pc_en    = 1'b0;
                        fd_flush = 1'b1;
                    end else begin
                        // The fetch now returning was issued before the redirect: drop it.
                        discard_fetch = 1'b1;
                        pc_redirect   = 1'b1;
                        pc_target     = pend_target_q;
                        fd_flush      = 1'b1;
                        state_d       = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pend_target_q <= 32'd0;
            stall_cnt_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued as each
// step is driven, then popped and compared against the DUT response.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_wait = 1'b0;
    logic        mem_wait = 1'b0;
    logic        d_branch_taken = 1'b0;
    logic        d_jump_taken = 1'b0;
    logic [31:0] d_target = 32'd0;
    logic [4:0]  d_rs = 5'd0;
    logic [4:0]  d_rt = 5'd0;
    logic        d_use_rs = 1'b0;
    logic        d_use_rt = 1'b0;
    logic        e_mem_read = 1'b0;
    logic [4:0]  e_rd = 5'd0;
    logic        pc_en, fd_en, de_en, em_en, mw_en;
    logic        fd_flush, de_flush, pc_redirect, discard_fetch;
    logic [31:0] pc_target;
    logic [31:0] stall_cnt;

    logic [40:0] exp_q[$];
    logic [31:0] exp_stall = 32'd0;
    int          n_vec = 0;
    int          n_fail = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .if_wait(if_wait), .mem_wait(mem_wait),
        .d_branch_taken(d_branch_taken), .d_jump_taken(d_jump_taken), .d_target(d_target),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .e_mem_read(e_mem_read), .e_rd(e_rd),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .discard_fetch(discard_fetch), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, pc_redirect, discard_fetch, pc_target}
    function automatic logic [40:0] ev(input logic pc, fd, de, em, mw, ff, df, rd, dc,
                                       input logic [31:0] t);
        return {pc, fd, de, em, mw, ff, df, rd, dc, t};
    endfunction

    function automatic logic [40:0] observed();
        return {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, pc_redirect,
                discard_fetch, pc_target};
    endfunction

    task automatic chk(input string tag, input logic [40:0] obs, input logic [40:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [40:0] e;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, observed(), e);
        end
    endtask

    task automatic step(input string tag, input logic rst_v, iw, mw, bt, jt,
                        input logic [31:0] tgt, input logic [4:0] rs, rt,
                        input logic urs, urt, emr, input logic [4:0] erd,
                        input logic [40:0] exp);
        @(negedge clk);
        reset = rst_v; if_wait = iw; mem_wait = mw; d_branch_taken = bt; d_jump_taken = jt;
        d_target = tgt; d_rs = rs; d_rt = rt; d_use_rs = urs; d_use_rt = urt;
        e_mem_read = emr; e_rd = erd;
        exp_q.push_back(exp);
        #1;
        pop_chk({tag, "/out"});
        @(posedge clk);
        if (rst_v) exp_stall = 32'd0;
        else if (!exp[40] && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        #1;
        chk({tag, "/stall"}, {9'd0, stall_cnt}, {9'd0, exp_stall});
    endtask

    localparam logic [31:0] T0 = 32'h0000_1234;

    initial begin
        // reset held: everything zero regardless of inputs
        step("reset", 1, 1, 0, 1, 0, 32'hCAFE_0000, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0));
        step("idle", 0, 0, 0, 0, 0, T0, 5'd1, 5'd2, 1, 1, 0, 5'd0,
             ev(1, 1, 1, 1, 1, 0, 0, 0, 0, T0));
        step("lu_rs", 0, 0, 0, 0, 0, T0, 5'd5, 5'd2, 1, 0, 1, 5'd5,
             ev(0, 0, 1, 1, 1, 0, 1, 0, 0, T0));
        step("lu_rd0", 0, 0, 0, 0, 0, T0, 5'd0, 5'd0, 1, 1, 1, 5'd0,
             ev(1, 1, 1, 1, 1, 0, 0, 0, 0, T0));
        step("lu_rt_br", 0, 0, 0, 1, 0, 32'h0000_0080, 5'd3, 5'd9, 1, 1, 1, 5'd9,
             ev(0, 0, 1, 1, 1, 0, 1, 0, 0, 32'h0000_0080));
        step("no_use", 0, 0, 0, 0, 0, T0, 5'd7, 5'd1, 0, 1, 1, 5'd7,
             ev(1, 1, 1, 1, 1, 0, 0, 0, 0, T0));
        step("br_ready", 0, 0, 0, 1, 0, 32'h0000_0040, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(1, 1, 1, 1, 1, 1, 0, 1, 0, 32'h0000_0040));
        step("mem_over", 0, 0, 1, 1, 0, 32'h0000_0040, 5'd4, 5'd0, 1, 0, 1, 5'd4,
             ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0040));
        step("if_wait", 0, 1, 0, 0, 0, T0, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 1, 1, 1, 1, 1, 0, 0, 0, T0));

        // jump while fetch outstanding: three stalled cycles, then redirect from held target
        step("jmp_w1", 0, 1, 0, 0, 1, 32'h0040_0100, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 1, 1, 1, 1, 1, 0, 0, 0, 32'h0040_0100));
        step("jmp_w2", 0, 1, 0, 0, 0, 32'h0040_0100, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 1, 1, 1, 1, 1, 0, 0, 0, 32'h0040_0100));
        step("jmp_w3", 0, 1, 0, 0, 0, 32'h0040_0100, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 1, 1, 1, 1, 1, 0, 0, 0, 32'h0040_0100));
        step("jmp_exit", 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 5'd6, 5'd0, 1, 0, 1, 5'd6,
             ev(1, 1, 1, 1, 1, 1, 0, 1, 1, 32'h0040_0100));
        step("run_again", 0, 0, 0, 0, 0, T0, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(1, 1, 1, 1, 1, 0, 0, 0, 0, T0));

        // mem_wait holds PEND even when if_wait falls; exit on the following cycle
        step("pend_in", 0, 1, 0, 1, 0, 32'h0000_0200, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 1, 1, 1, 1, 1, 0, 0, 0, 32'h0000_0200));
        step("pend_mem", 0, 0, 1, 0, 0, 32'h0000_0300, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0300));
        step("pend_out", 0, 0, 0, 0, 0, 32'h0000_0300, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(1, 1, 1, 1, 1, 1, 0, 1, 1, 32'h0000_0200));

        // asynchronous reset while PEND
        step("rp_in", 0, 1, 0, 0, 1, 32'h0000_0100, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 1, 1, 1, 1, 1, 0, 0, 0, 32'h0000_0100));
        #2;
        reset = 1'b1;
        exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0));
        exp_stall = 32'd0;
        #1;
        pop_chk("rp_async/out");
        chk("rp_async/stall", {9'd0, stall_cnt}, {9'd0, exp_stall});
        step("rp_hold", 1, 1, 0, 0, 0, 32'h0000_0100, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0));
        step("rp_after", 0, 0, 0, 0, 0, 32'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0,
             ev(1, 1, 1, 1, 1, 0, 0, 0, 0, 32'd0));

        // saturation: preload the counter just below its ceiling
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        exp_stall = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            step("sat", 0, 1, 0, 0, 0, T0, 5'd0, 5'd0, 0, 0, 0, 5'd0,
                 ev(0, 1, 1, 1, 1, 1, 0, 0, 0, T0));
        end
        chk("sat_final", {9'd0, stall_cnt}, {9'd0, 32'hFFFF_FFFF});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. Each cycle it decides, from fetch/memory wait status, decode-stage branch/jump resolution and execute-stage load information, which pipeline registers advance, which take a bubble, and whether the PC is redirected. It holds a redirect that arrives while an instruction fetch is still outstanding, and counts stall cycles for performance analysis.

## Interface
Parameters:
- none

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- if_wait  input  1  fetch bus has not returned the instruction this cycle
- mem_wait  input  1  memory-stage data access not complete this cycle
- d_branch_taken  input  1  decode resolved a taken BEQ
- d_jump_taken  input  1  decode holds a J
- d_target  input  32  redirect address from decode (branch or jump)
- d_rs, d_rt  input  5 each  decode source register numbers
- d_use_rs, d_use_rt  input  1 each  decode instruction reads rs / rt
- e_mem_read  input  1  execute-stage instruction is a load
- e_rd  input  5  execute-stage destination register
- pc_en, fd_en, de_en, em_en, mw_en  output  1 each  PC / stage-register advance enables
- fd_flush, de_flush  output  1 each  load a bubble into F/D / D/E register (takes effect only when that register is enabled)
- pc_redirect  output  1  PC loads pc_target instead of pc+4
- pc_target  output  32  redirect address
- discard_fetch  output  1  instruction returning this cycle is wrong-path; fetch drops it
- stall_cnt  output  32  cycles with pc_en=0 since reset, saturating

## Operation
- State: FSM {RUN, PEND}; pend_target[31:0]; stall_cnt[31:0].
- redirect = d_branch_taken | d_jump_taken.
- load_use = e_mem_read & e_rd!=0 & ((d_use_rs & d_rs==e_rd) | (d_use_rt & d_rt==e_rd)).
- Default (RUN, no event): all enables 1, flushes 0, pc_redirect 0, discard_fetch 0, pc_target = d_target.
- Priority, highest first, in RUN:
  1. mem_wait: all enables 0, flushes 0, pc_redirect 0. Decode is held, so a pending redirect re-presents next cycle.
  2. load_use: pc_en=0, fd_en=0, de_flush=1 (bubble to EX); de/em/mw_en=1; redirect ignored (decode operands stale).
  3. redirect & !if_wait: pc_redirect=1, pc_target=d_target, fd_flush=1 (drop wrong-path fetch); all enables 1.
  4. redirect & if_wait: pc_en=0, fd_flush=1, other enables 1; capture pend_target<=d_target; next state PEND.
  5. if_wait alone: pc_en=0, fd_flush=1 (bubble into decode); other enables 1.
- PEND: decode inputs ignored (decode holds a bubble).
  - mem_wait: all enables 0; stay PEND.
  - else if if_wait: pc_en=0, fd_flush=1, others 1; stay PEND.
  - else: discard_fetch=1, pc_redirect=1, pc_target=pend_target, fd_flush=1, all enables 1; next RUN.
- Fetch unit holds returned data while pc_en=0; hazard_ctrl relies on this.
- stall_cnt: +1 on every cycle where pc_en=0 and reset low; holds at 32'hFFFF_FFFF.

## Timing
- All outputs except stall_cnt are combinational from current state and inputs; same-cycle response.
- State, pend_target, stall_cnt update on rising clk.
- Redirect latency: taken branch with fetch ready → PC = target at next edge (one wrong-path instruction flushed). With fetch outstanding → PC = target on the edge after if_wait falls.
- Load-use: exactly one bubble per dependence if the load advances; extra cycles if mem_wait also asserts.
- Reset (asynchronous, any state including PEND): state=RUN, pend_target=0, stall_cnt=0 immediately. While reset high: all enables 0, flushes 0, pc_redirect 0, discard_fetch 0, pc_target 0. Pending redirect is lost.
- mem_wait and if_wait falling in the same cycle in PEND: mem_wait wins; exit PEND next cycle with if_wait=0.
- e_rd=0 never causes a load-use stall.

## Test plan
- Load-use: e_mem_read=1, e_rd=5, d_rs=5, d_use_rs=1, one cycle → pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1; stall_cnt 0→1.
- Taken branch, fetch ready: d_branch_taken=1, d_target=0x0000_0040, if_wait=0 → pc_redirect=1, pc_target=0x40, fd_flush=1, all enables 1; state RUN.
- Jump during fetch wait: d_jump_taken=1, d_target=0x0040_0100, if_wait=1 for 3 cycles → pc_en=0 three cycles, PEND; cycle if_wait=0 → discard_fetch=1, pc_redirect=1, pc_target=0x0040_0100; stall_cnt +3.
- mem_wait over load-use and branch: mem_wait=1 with load_use and d_branch_taken=1 → all enables 0, flushes 0, pc_redirect 0.
- Reset in PEND: enter PEND (target 0x100), assert reset mid-cycle → outputs zero asynchronously; after release with if_wait=0, no redirect, discard_fetch=0, stall_cnt=0.
- Saturation: force stall_cnt near max (run 2^32 stall cycles in fast sim or via backdoor to 0xFFFF_FFFE), stall 3 cycles → stays 0xFFFF_FFFF.
